// File: rtl/matmul_pkg.sv
// matmul_pkg
//   Shared constants and types for the 4x4 MAC-array operand feeder.
//   DATA_W  : signed operand element width
//   ACC_W   : accumulator width that holds an M-term dot product without overflow
//   M       : matrix dimension
//   BEAT_W  : width of the input beat counter (covers 2*M*M beats)
//   K_W     : width of the slice index k (minimum 1 bit)
package matmul_pkg;

  localparam int DATA_W = 8;
  localparam int M      = 4;
  localparam int ACC_W  = 2 * DATA_W + $clog2(M);
  localparam int BEAT_W = $clog2(2 * M * M);
  localparam int K_W    = (M > 1) ? $clog2(M) : 1;

  typedef logic signed [DATA_W-1:0] operand_t;

  typedef enum logic [1:0] {LOAD, CLEAR, COMPUTE, DONE} feeder_state_t;

endpackage

// File: rtl/matmul_operand_feeder_regfile.sv
// operand_regfile
//   Holds the A and B operand matrices as one flat buffer of 2*M*M elements:
//   indices 0..M*M-1 are A row-major, M*M..2*M*M-1 are B row-major.
//   Ports:
//     clk            clock
//     we, wr_idx,    write port (one element per cycle)
//     wr_data
//     k              slice index for the read port
//     a_col          A[i][k] for i = 0..M-1
//     b_row          B[k][j] for j = 0..M-1
//   No reset: contents are don't-care until a full load has happened.
module operand_regfile
  import matmul_pkg::*;
(
  input  logic                         clk,
  input  logic                         we,
  input  logic [BEAT_W-1:0]            wr_idx,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic [K_W-1:0]               k,
  output logic [M-1:0][DATA_W-1:0]     a_col,
  output logic [M-1:0][DATA_W-1:0]     b_row
);

  operand_t mem [2*M*M];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_idx] <= operand_t'(wr_data);
    end
  end

  always_comb begin
    a_col = '0;
    b_row = '0;
    for (int i = 0; i < M; i++) begin
      a_col[i] = mem[BEAT_W'(i * M) + BEAT_W'(k)];
      b_row[i] = mem[BEAT_W'(M * M) + BEAT_W'(k) * BEAT_W'(M) + BEAT_W'(i)];
    end
  end

endmodule

// File: rtl/matmul_operand_feeder.sv
// matmul_operand_feeder
//   Buffers A then B from a serial element stream, clears the MAC array,
//   then drives M enabled cycles of k-indexed operand slices so the array
//   accumulates C = A*B. Holds done until the consumer acknowledges.
//   Ports:
//     clk, rst           clock, synchronous active-high reset
//     in_valid/in_ready  element stream handshake, in_data the element
//     mac_clr, mac_en    array accumulator clear pulse / enable
//     a_out, b_out       per-cell array operands, a_out[i][j], b_out[i][j]
//     busy               high in CLEAR, COMPUTE and DONE
//     done, res_ack      product ready / consumer acknowledge
//     op_count           completed operations; counts only when
//                        MATMUL_FEEDER_PERF_CNT_EN is defined, else tied to 0
//
//   state   | meaning
//   LOAD    | accepting A then B elements into the buffer
//   CLEAR   | one-cycle accumulator clear
//   COMPUTE | M cycles of operand slices, k = 0..M-1
//   DONE    | product held in the array, waiting for res_ack
module matmul_operand_feeder
  import matmul_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_W-1:0]                in_data,
  output logic                             mac_clr,
  output logic                             mac_en,
  output logic [M-1:0][M-1:0][DATA_W-1:0]  a_out,
  output logic [M-1:0][M-1:0][DATA_W-1:0]  b_out,
  output logic                             busy,
  output logic                             done,
  input  logic                             res_ack,
  output logic [31:0]                      op_count
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(2 * M * M - 1);
  localparam logic [K_W-1:0]    LAST_K    = K_W'(M - 1);

  feeder_state_t           state, state_nxt;
  logic [BEAT_W-1:0]       beat_cnt, beat_cnt_nxt;
  logic [K_W-1:0]          k, k_nxt;
  logic                    beat_fire;
  logic [M-1:0][DATA_W-1:0] a_col, b_row;

  // Read port is addressed with k_nxt so the registered operand outputs
  // line up with the cycle in which mac_en is high.
  operand_regfile u_regfile (
    .clk     (clk),
    .we      (beat_fire),
    .wr_idx  (beat_cnt),
    .wr_data (in_data),
    .k       (k_nxt),
    .a_col   (a_col),
    .b_row   (b_row)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LOAD;
      beat_cnt <= '0;
      k        <= '0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
      k        <= k_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    k_nxt        = k;
    beat_fire    = 1'b0;
    case (state)
      LOAD: begin
        if (in_valid) begin
          beat_fire = 1'b1;
          if (beat_cnt == LAST_BEAT) begin
            state_nxt    = CLEAR;
            beat_cnt_nxt = '0;
          end else begin
            beat_cnt_nxt = beat_cnt + 1'b1;
          end
        end
      end
      CLEAR: begin
        state_nxt = COMPUTE;
        k_nxt     = '0;
      end
      COMPUTE: begin
        if (k == LAST_K) begin
          state_nxt = DONE;
          k_nxt     = '0;
        end else begin
          k_nxt = k + 1'b1;
        end
      end
      DONE: begin
        if (res_ack) begin
          state_nxt = LOAD;
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  assign in_ready = (state == LOAD);
  assign busy     = (state != LOAD);

  // Array-facing outputs are flops decoded from next-state.
  always_ff @(posedge clk) begin
    if (rst) begin
      mac_clr <= 1'b0;
      mac_en  <= 1'b0;
      done    <= 1'b0;
      a_out   <= '0;
      b_out   <= '0;
    end else begin
      mac_clr <= (state_nxt == CLEAR);
      mac_en  <= (state_nxt == COMPUTE);
      done    <= (state_nxt == DONE);
      for (int i = 0; i < M; i++) begin
        for (int j = 0; j < M; j++) begin
          a_out[i][j] <= (state_nxt == COMPUTE) ? a_col[i] : '0;
          b_out[i][j] <= (state_nxt == COMPUTE) ? b_row[j] : '0;
        end
      end
    end
  end

`ifdef MATMUL_FEEDER_PERF_CNT_EN
  logic [31:0] op_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      op_count_q <= '0;
    end else if (state == DONE && res_ack) begin
      op_count_q <= op_count_q + 32'd1;
    end
  end

  assign op_count = op_count_q;
`else
  assign op_count = '0;
`endif

endmodule

// File: tb/tb_matmul_operand_feeder.sv
module tb_matmul_operand_feeder;
  import matmul_pkg::*;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, mac_clr, mac_en, busy, done, res_ack;
  logic [DATA_W-1:0] in_data;
  logic [M-1:0][M-1:0][DATA_W-1:0] a_out, b_out;
  logic [31:0] op_count;

  matmul_operand_feeder dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .mac_clr  (mac_clr),
    .mac_en   (mac_en),
    .a_out    (a_out),
    .b_out    (b_out),
    .busy     (busy),
    .done     (done),
    .res_ack  (res_ack),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_cyc = 0;
  int mac_en_cnt = 0;
  int ready_viol = 0;
  int ma [4][4];
  int mb [4][4];
  longint acc [4][4];
  longint snap [4][4];

  // Array model: what the MAC array would accumulate from the feeder outputs.
  always @(posedge clk) begin
    cyc++;
    if (mac_en) mac_en_cnt++;
    if (busy && in_ready) ready_viol++;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        if (mac_clr) acc[i][j] = 0;
        else if (mac_en)
          acc[i][j] = acc[i][j] + longint'($signed(a_out[i][j])) * longint'($signed(b_out[i][j]));
      end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load_op(input int gapmax);
    mac_en_cnt = 0;
    for (int idx = 0; idx < 32; idx++) begin
      int g;
      g = (gapmax > 0) ? int'($urandom_range(gapmax)) : 0;
      in_valid = 1'b0;
      repeat (g) @(negedge clk);
      in_valid = 1'b1;
      in_data = (idx < 16) ? 8'(ma[idx/4][idx%4]) : 8'(mb[(idx-16)/4][(idx-16)%4]);
      if (idx == 31) last_cyc = cyc;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, longint'(done), 1);
  endtask

  task automatic check_product(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        longint e;
        e = 0;
        for (int kk = 0; kk < 4; kk++) e += longint'(ma[i][kk]) * longint'(mb[kk][j]);
        if (acc[i][j] !== e) begin
          bad++;
          $display("  %s cell[%0d][%0d] observed=%0d expected=%0d", tag, i, j, acc[i][j], e);
        end
      end
    chk({tag, "_product_bad_cells"}, bad, 0);
  endtask

  task automatic ack_op(input string tag);
    res_ack = 1'b1;
    @(negedge clk);
    res_ack = 1'b0;
    chk({tag, "_done_after_ack"}, longint'(done), 0);
    chk({tag, "_ready_after_ack"}, longint'(in_ready), 1);
  endtask

  task automatic run_op(input string tag, input int gapmax);
    load_op(gapmax);
    wait_done(tag);
    chk({tag, "_latency"}, cyc - last_cyc, 6);
    chk({tag, "_mac_en_cycles"}, mac_en_cnt, 4);
    check_product(tag);
    ack_op(tag);
  endtask

  initial begin
    int bad;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; res_ack = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_mac_en", longint'(mac_en), 0);
    chk("rst_mac_clr", longint'(mac_clr), 0);
    chk("rst_op_count", longint'(op_count), 0);

    // Identity A, B = 1..16, back-to-back beats
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ma[i][j] = (i == j) ? 1 : 0;
        mb[i][j] = i * 4 + j + 1;
      end
    load_op(0);
    chk("ident_mac_clr", longint'(mac_clr), 1);
    chk("ident_busy", longint'(busy), 1);
    wait_done("ident");
    chk("ident_latency", cyc - last_cyc, 6);
    chk("ident_mac_en_cycles", mac_en_cnt, 4);
    chk("ident_acc00", acc[0][0], 1);
    chk("ident_acc33", acc[3][3], 16);
    check_product("ident");
    ack_op("ident");

    // A all -1, B all 127: check operands on every COMPUTE cycle
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ma[i][j] = -1;
        mb[i][j] = 127;
      end
    load_op(0);
    chk("neg_mac_clr", longint'(mac_clr), 1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bad = 0;
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          if ($signed(a_out[i][j]) !== -8'sd1) bad++;
          if ($signed(b_out[i][j]) !== 8'sd127) bad++;
        end
      chk("neg_compute_mac_en", longint'(mac_en), 1);
      chk("neg_compute_operands_bad", bad, 0);
    end
    @(negedge clk);
    chk("neg_done", longint'(done), 1);
    chk("neg_a_out_idle", longint'(a_out), 0);
    chk("neg_acc_cell", acc[2][1], -508);
    check_product("neg");
    ack_op("neg");

    // Random values with random input gaps
    ready_viol = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ma[i][j] = int'($urandom_range(255)) - 128;
        mb[i][j] = int'($urandom_range(255)) - 128;
      end
    ma[0][0] = -128; mb[0][0] = -128; ma[1][2] = 127;
    run_op("rand", 5);
    chk("rand_ready_while_busy", ready_viol, 0);

    // Hold done for 20 cycles with in_valid high
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ma[i][j] = i - j;
        mb[i][j] = (i + 1) * (j - 2);
      end
    load_op(0);
    wait_done("hold");
    check_product("hold");
    snap = acc;
    ready_viol = 0;
    bad = 0;
    in_valid = 1'b1;
    in_data = 8'h55;
    repeat (20) begin
      @(negedge clk);
      if (done !== 1'b1) bad++;
    end
    chk("hold_done_stable_bad", bad, 0);
    chk("hold_acc_stable", longint'(snap == acc), 1);
    chk("hold_ready_while_busy", ready_viol, 0);
    ack_op("hold");
    in_valid = 1'b0;
    // A fresh load must land at beat 0 if nothing was consumed while held.
    ma[0][0] = 3; ma[3][3] = -7; mb[0][3] = 9;
    run_op("after_hold", 0);

    // Reset in the 2nd COMPUTE cycle
    load_op(0);
    @(negedge clk);
    chk("rstmid_first_compute", longint'(mac_en), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_mac_en", longint'(mac_en), 0);
    chk("rstmid_mac_clr", longint'(mac_clr), 0);
    chk("rstmid_done", longint'(done), 0);
    chk("rstmid_busy", longint'(busy), 0);
    chk("rstmid_in_ready", longint'(in_ready), 1);
    chk("rstmid_a_out", longint'(a_out), 0);
    chk("rstmid_b_out", longint'(b_out), 0);
    chk("rstmid_op_count", longint'(op_count), 0);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ma[i][j] = int'($urandom_range(255)) - 128;
        mb[i][j] = int'($urandom_range(255)) - 128;
      end
    run_op("post_rst", 0);
    run_op("post_rst2", 2);
    run_op("post_rst3", 0);
`ifdef MATMUL_FEEDER_PERF_CNT_EN
    chk("op_count", longint'(op_count), 3);
`else
    chk("op_count", longint'(op_count), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
